// File: rtl/embarcadovga_processor_cpu_mult_seq_if.sv
// rtl/embarcadovga_processor_cpu_mult_seq_if.sv - request/response/multiplier-cell bundle for the sequential multiplier
interface embarcadovga_processor_cpu_mult_seq_if;
    // request side
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [1:0]  req_op;
    // multiplier cell side
    logic [31:0] E_src1;
    logic [31:0] E_src2;
    logic        M_en;
    logic [31:0] M_mul_cell_p1;
    logic [31:0] M_mul_cell_p2;
    logic [31:0] M_mul_cell_p3;
    // response side
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    // sequencer view
    modport slave (
        input  req_valid, req_src1, req_src2, req_op,
        output req_ready,
        output E_src1, E_src2, M_en,
        input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        output rsp_valid, rsp_data,
        input  rsp_ready
    );

    // requester / cell / consumer view
    modport master (
        output req_valid, req_src1, req_src2, req_op,
        input  req_ready,
        input  E_src1, E_src2, M_en,
        output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        input  rsp_valid, rsp_data,
        output rsp_ready
    );
endinterface

// File: rtl/embarcadovga_processor_cpu_mult_seq.sv
// rtl/embarcadovga_processor_cpu_mult_seq.sv - sequences a 16x16 multiplier cell into 32-bit MUL/MULX operations
module embarcadovga_processor_cpu_mult_seq (
    input logic                                   clk,
    input logic                                   reset_n,
    embarcadovga_processor_cpu_mult_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        W1,
        P2,
        W2,
        FIX,
        DONE
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b10;
    localparam logic [1:0] OP_MULXSU = 2'b11;

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        m_en_q;
    logic [31:0] e_src1_q;
    logic [31:0] e_src2_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  op_q;
    logic [31:0] p1_q;
    logic [31:0] p2_q;
    logic [31:0] p3_q;
    logic [31:0] hi_q;

    logic [31:0] lo_d;
    logic [31:0] hi_u_d;
    logic [31:0] fix_d;

    // Low word straight from the first cell pass; the cross terms only contribute their low halves.
    assign lo_d = bus.M_mul_cell_p1 + ((bus.M_mul_cell_p2 + bus.M_mul_cell_p3) << 16);

    // Unsigned high word: full 64-bit sum of all four partial products, cell now holds A_hi*B_hi.
    assign hi_u_d = 32'(({32'h0, p1_q}
                       + {16'h0, p2_q, 16'h0}
                       + {16'h0, p3_q, 16'h0}
                       + {bus.M_mul_cell_p1, 32'h0}) >> 32);

    // Signed corrections: a negative operand contributes -(other operand) * 2^32 to the product.
    always_comb begin
        fix_d = hi_q;
        if ((op_q == OP_MULXSS || op_q == OP_MULXSU) && a_q[31]) begin
            fix_d = fix_d - b_q;
        end
        if (op_q == OP_MULXSS && b_q[31]) begin
            fix_d = fix_d - a_q;
        end
    end

    // Control FSM with registered outputs, each set on the edge entering the state that owns it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            m_en_q      <= 1'b0;
            e_src1_q    <= 32'h0;
            e_src2_q    <= 32'h0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            op_q        <= 2'b00;
            p1_q        <= 32'h0;
            p2_q        <= 32'h0;
            p3_q        <= 32'h0;
            hi_q        <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        a_q         <= bus.req_src1;
                        b_q         <= bus.req_src2;
                        op_q        <= bus.req_op;
                        e_src1_q    <= bus.req_src1;
                        e_src2_q    <= bus.req_src2;
                        m_en_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        state_q     <= P1;
                    end
                end
                P1: begin
                    m_en_q   <= 1'b0;
                    e_src1_q <= 32'h0;
                    e_src2_q <= 32'h0;
                    state_q  <= W1;
                end
                W1: begin
                    p1_q <= bus.M_mul_cell_p1;
                    p2_q <= bus.M_mul_cell_p2;
                    p3_q <= bus.M_mul_cell_p3;
                    if (op_q == OP_MUL) begin
                        rsp_data_q  <= lo_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        e_src1_q <= {16'h0, a_q[31:16]};
                        e_src2_q <= {16'h0, b_q[31:16]};
                        m_en_q   <= 1'b1;
                        state_q  <= P2;
                    end
                end
                P2: begin
                    m_en_q   <= 1'b0;
                    e_src1_q <= 32'h0;
                    e_src2_q <= 32'h0;
                    state_q  <= W2;
                end
                W2: begin
                    hi_q    <= hi_u_d;
                    state_q <= FIX;
                end
                FIX: begin
                    rsp_data_q  <= fix_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready is forced low combinationally while reset is held, even if the state is already IDLE.
    assign bus.req_ready = req_ready_q & reset_n;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.M_en      = m_en_q;
    assign bus.E_src1    = e_src1_q;
    assign bus.E_src2    = e_src2_q;

endmodule

// File: doc/embarcadovga_processor_cpu_mult_seq.md
EMBARCADOVGA_PROCESSOR_CPU_MULT_SEQ -- requirements
Module: embarcadovga_processor_cpu_mult_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have a single clock and a synchronous, active-low reset, as below:
- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
REQ-003 Request-side ports SHALL be:
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_src1  in  32  operand A.
- req_src2  in  32  operand B.
- req_op  in  2  00 MUL (low 32), 01 MULXUU, 10 MULXSS, 11 MULXSU (A signed, B unsigned); 01/10/11 return high 32.
REQ-004 Multiplier-cell-side ports SHALL be:
- E_src1  out  32  operand A to the cell.
- E_src2  out  32  operand B to the cell.
- M_en  out  1  cell register enable.
- M_mul_cell_p1  in  32  cell result, A[15:0]*B[15:0].
- M_mul_cell_p2  in  32  cell result, A[15:0]*B[31:16].
- M_mul_cell_p3  in  32  cell result, A[31:16]*B[15:0].
REQ-005 Response-side ports SHALL be:
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  result word.

Function
REQ-006 The cell SHALL be treated as having 1-cycle latency: products of E_src1/E_src2 are valid from the edge on which M_en=1 and hold while M_en=0.
REQ-007 The FSM states SHALL be IDLE, P1, W1, P2, W2, FIX, DONE.
REQ-008 IDLE SHALL behave as follows:
- req_ready=1.
- On req_valid&req_ready, latch A, B and op, then go to P1.
- req_ready SHALL be 0 in all other states.
REQ-009 P1 SHALL drive E_src1=A, E_src2=B, M_en=1, then go to W1.
REQ-010 W1 SHALL behave as follows:
- M_en=0.
- Register p1, p2, p3.
- Compute lo = p1 + ((p2+p3)<<16) mod 2^32.
- If op=00, load rsp_data=lo and go to DONE; else go to P2.
REQ-011 P2 SHALL drive E_src1={16'h0,A[31:16]}, E_src2={16'h0,B[31:16]}, M_en=1, then go to W2.
REQ-012 W2 SHALL behave as follows:
- Take p4=M_mul_cell_p1.
- Compute hi_u = bits[63:32] of (p1 + (p2<<16) + (p3<<16) + (p4<<32)).
- Intermediate sums SHALL be at least 34 bits wide, so no carry is lost.
- Go to FIX.
REQ-013 FIX SHALL compute rsp_data as below, modulo 2^32, then go to DONE:
- MULXUU: hi_u.
- MULXSS: hi_u − (A[31]?B:0) − (B[31]?A:0).
- MULXSU: hi_u − (A[31]?B:0).
REQ-014 DONE SHALL behave as follows:
- rsp_valid=1; rsp_data is held stable.
- On rsp_ready, go to IDLE.
- rsp_valid SHALL be 0 in all other states.
REQ-015 Latency from the accept edge to rsp_valid SHALL be 3 cycles for MUL and 6 cycles for high-word ops, when not back-pressured.
REQ-016 The block SHALL hold at most one operation in flight; req_valid outside IDLE SHALL be ignored.
REQ-017 Outside P1/P2, E_src1 and E_src2 SHALL be 0 and M_en SHALL be 0.
REQ-018 A request SHALL NOT be accepted in the same cycle as a response handshake; it is accepted in the following IDLE cycle.

Reset
REQ-019 While reset_n=0 at an edge, the next state SHALL be IDLE, with these outputs:
- rsp_valid=0, rsp_data=0, M_en=0.
- E_src1=E_src2=0.
- req_ready=0 during any cycle in which reset_n=0.
REQ-020 Reset asserted mid-operation (any state) SHALL abort that operation with no response; the first request after reset SHALL complete correctly.

Verification
REQ-021 A bench SHALL cover these directed scenarios:
- MUL A=0x00010003, B=0x00020005 -> rsp_data=0x000B000F, rsp_valid 3 cycles after accept.
- MULXUU A=B=0xFFFFFFFF -> rsp_data=0xFFFFFFFE, rsp_valid 6 cycles after accept; M_en high exactly 2 cycles.
- MULXSS A=0xFFFFFFFF, B=0x00000002 -> rsp_data=0xFFFFFFFF.
- MULXSU A=0x80000000, B=0x80000000 -> rsp_data=0xC0000000.
- MUL with rsp_ready=0 for 4 cycles and req_valid held high -> rsp_valid/rsp_data stable, req_ready=0, second request accepted only after the response handshake.
- reset_n=0 for 1 cycle while in W2 -> IDLE next cycle, rsp_valid never asserted for the aborted op; next MUL 0x7*0x9 -> 0x3F.
